// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic unit blocks.
package alu_pkg;

  // Default operand width for the sequential divider.
  localparam int DIV_WIDTH = 8;

  // Divider control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_cla.sv
// N-bit subtractor a - b, computed as a + ~b + 1 with generate/propagate carries.
// The carry-out is not exported; callers size N one bit wider and read the sign bit.
module sub_cla #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff
);

  logic [N-1:0] b_inv;
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N-1:0] c;

  assign b_inv = ~b;
  assign g     = a & b_inv;
  assign p     = a ^ b_inv;

  // Carry lookahead recurrence; carry-in of 1 completes the two's complement.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign diff = p ^ c;

endmodule

// File: rtl/div_restoring_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | nothing in progress, waiting for start
// RUN   | shift / trial-subtract / restore, WIDTH iterations
// DONE  | single-cycle result strobe; a new start is accepted here
module div_restoring_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   a_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   a_next;
  logic [WIDTH-1:0] q_next;
  logic             trial_ok;

  // A never holds a value >= D, so its top bit is always zero and is dropped by the shift.
  assign a_shift = {a[WIDTH-1:0], q[WIDTH-1]};

  sub_cla #(.N(WIDTH + 1)) u_sub (
    .a    (a_shift),
    .b    ({1'b0, d}),
    .diff (trial)
  );

  // Keep the trial difference when it did not go negative, otherwise restore.
  always_comb begin
    trial_ok = ~trial[WIDTH];
    a_next   = trial_ok ? trial : a_shift;
    q_next   = {q[WIDTH-2:0], trial_ok};
  end

  // Control FSM, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            if (divisor != '0) begin
              a     <= '0;
              q     <= dividend;
              d     <= divisor;
              cnt   <= '0;
              state <= RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              state       <= DONE;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            quotient    <= q_next;
            remainder   <= a_next[WIDTH-1:0];
            div_by_zero <= 1'b0;
            state       <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status flags decode directly from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // The partial remainder must never carry a set top bit while iterating.
  a_top_clear: assert property (@(posedge clk) disable iff (rst) (state == RUN) |-> !a[WIDTH]);

endmodule

// File: tb/tb_div_restoring_seq.sv
// Self-checking bench for div_restoring_seq (WIDTH = 8).
module tb_div_restoring_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div_restoring_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dvs;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         edbz;
    int           elat;
    int           ebusy;
  } vec_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse consumes the oldest pending expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
      end
    end
  end

  function automatic exp_t model(input logic [W-1:0] dvd, input logic [W-1:0] dvs);
    exp_t e;
    if (dvs == 0) begin
      e.q = '1; e.r = dvd; e.dbz = 1'b1;
    end else begin
      e.q = dvd / dvs; e.r = dvd % dvs; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Drive one start cycle at the current negedge and record the expectation.
  task automatic start_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input exp_t e);
    sb.push_back(e);
    start = 1'b1; dividend = dvd; divisor = dvs;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called one negedge after the accepting edge; returns at the negedge of the DONE cycle.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1; busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  vec_t vecs[6];
  int   lat, bn;
  exp_t e;

  initial begin
    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 9, 8};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 9, 8};
    vecs[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 9, 8};
    vecs[3] = '{8'd200, 8'd200, 8'd1,   8'd0,  1'b0, 9, 8};
    vecs[4] = '{8'd42,  8'd0,   8'd255, 8'd42, 1'b1, 1, 0};
    vecs[5] = '{8'd42,  8'd6,   8'd7,   8'd0,  1'b0, 9, 8};

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven vectors, with an idle cycle between operations.
    for (int i = 0; i < 6; i++) begin
      e.q = vecs[i].eq; e.r = vecs[i].er; e.dbz = vecs[i].edbz;
      start_op(vecs[i].dvd, vecs[i].dvs, e);
      wait_done(lat, bn);
      check($sformatf("latency_%0d", i), 32'(lat), 32'(vecs[i].elat));
      check($sformatf("busy_cycles_%0d", i), 32'(bn), 32'(vecs[i].ebusy));
      @(negedge clk);
      check($sformatf("back_to_idle_%0d", i), 32'({busy, done}), 32'd0);
    end

    // start during RUN is ignored.
    e.q = 8'd14; e.r = 8'd2; e.dbz = 1'b0;
    start_op(8'd100, 8'd7, e);
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0; dividend = '0; divisor = '0;
    wait_done(lat, bn);
    check("ignored_start_lat", 32'(lat + 2), 32'd9);
    @(negedge clk);

    // Reset mid-RUN discards the result; a start coincident with rst is ignored.
    e.q = 8'd14; e.r = 8'd2; e.dbz = 1'b0;
    start_op(8'd100, 8'd7, e);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 8'd81; divisor = 8'd9;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (10) @(negedge clk);
    check("midrst_no_done_or_busy", 32'({busy, done}), 32'd0);
    e.q = 8'd9; e.r = 8'd0; e.dbz = 1'b0;
    start_op(8'd81, 8'd9, e);
    wait_done(lat, bn);
    check("after_rst_lat", 32'(lat), 32'd9);
    @(negedge clk);

    // Back-to-back: second start issued in the DONE cycle of the first.
    e.q = 8'd14; e.r = 8'd2; e.dbz = 1'b0;
    start_op(8'd100, 8'd7, e);
    wait_done(lat, bn);
    e.q = 8'd8; e.r = 8'd4; e.dbz = 1'b0;
    start_op(8'd60, 8'd7, e);
    wait_done(lat, bn);
    check("b2b_lat", 32'(lat), 32'd9);
    check("b2b_busy", 32'(bn), 32'd8);

    // Randomized sweep, chained back-to-back, against the reference model.
    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = ($urandom_range(0, 9) == 0) ? '0 : W'($urandom);
      start_op(x, y, model(x, y));
      wait_done(lat, bn);
      check("rand_lat", 32'(lat), (y == 0) ? 32'd1 : 32'd9);
    end
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
